// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit that owns HI/LO. MTHI/MTLO write hi/lo at the start edge.
// Latency: busy is high for WIDTH+1 cycles (WIDTH CALC steps plus one FIX); new hi/lo appear with busy low.
// Backpressure: no handshake. stall holds a HI/LO consumer in decode while busy or while a mult/div issues.
// Ports: clock/reset (async, active-high); e_start/e_op/e_a/e_b capture execute operands;
//        d_hilo_use marks a decode HI/LO user; hi/lo are committed registers; busy/done/div_by_zero
//        report status; stall goes to the hazard unit.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             e_start,
  input  logic [2:0]       e_op,
  input  logic [WIDTH-1:0] e_a,
  input  logic [WIDTH-1:0] e_b,
  input  logic             d_hilo_use,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic             stall
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;
  state_t state_q, state_d;

  logic [WIDTH-1:0] hi_q, lo_q;
  logic             done_q, dbz_q;
  logic [CW-1:0]    cnt_q;
  // Working registers: work_hi/work_lo hold the running product or {remainder, dividend/quotient};
  // opnd holds the multiplicand or divisor magnitude.
  logic [WIDTH-1:0] work_hi_q, work_lo_q, opnd_q;
  logic             is_div_q, neg_q, rneg_q, dbz_pend_q;

  logic accept, step, commit, mt_hi, mt_lo;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (e_start && !e_op[2]) state_d = S_CALC;
      S_CALC:  if (cnt_q == '0) state_d = S_FIX;
      S_FIX:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  // Starts are only honoured in IDLE; a start while busy is dropped without any state change.
  always_comb begin
    accept = 1'b0;
    step   = 1'b0;
    commit = 1'b0;
    mt_hi  = 1'b0;
    mt_lo  = 1'b0;
    case (state_q)
      S_IDLE: begin
        accept = e_start && !e_op[2];
        mt_hi  = e_start && (e_op == 3'b100);
        mt_lo  = e_start && (e_op == 3'b101);
      end
      S_CALC:  step   = 1'b1;
      S_FIX:   commit = 1'b1;
      default: ;
    endcase
  end

  // ---------------- operand capture ----------------
  // e_op[0]==0 selects the signed flavour, e_op[1]==1 selects divide.
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  always_comb begin
    a_neg = !e_op[0] && e_a[WIDTH-1];
    b_neg = !e_op[0] && e_b[WIDTH-1];
    a_mag = a_neg ? -e_a : e_a;
    b_mag = b_neg ? -e_b : e_b;
  end

  // ---------------- one iteration step ----------------
  logic [WIDTH:0]   mul_sum, div_shift, div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] step_hi, step_lo;
  always_comb begin
    // Shift-add: add multiplicand when the multiplier LSB is set, then shift the pair right.
    mul_sum   = {1'b0, work_hi_q} + (work_lo_q[0] ? {1'b0, opnd_q} : '0);
    // Restoring divide: bring in the next dividend bit, keep the difference if non-negative.
    div_shift = {work_hi_q, work_lo_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
    div_ge    = !div_diff[WIDTH];
    if (is_div_q) begin
      step_hi = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
      step_lo = {work_lo_q[WIDTH-2:0], div_ge};
    end else begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], work_lo_q[WIDTH-1:1]};
    end
  end

  // ---------------- sign fix-up ----------------
  // A zero divisor leaves quotient=all ones and remainder=|a|; the remainder's sign fix restores a,
  // and the quotient is forced so a negative dividend still reports all ones.
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rem, res_hi, res_lo;
  always_comb begin
    prod = {work_hi_q, work_lo_q};
    quo  = work_lo_q;
    rem  = work_hi_q;
    if (neg_q) begin
      prod = -prod;
      quo  = -quo;
    end
    if (rneg_q)     rem = -rem;
    if (dbz_pend_q) quo = '1;
    if (is_div_q) begin
      res_hi = rem;
      res_lo = quo;
    end else begin
      res_hi = prod[2*WIDTH-1:WIDTH];
      res_lo = prod[WIDTH-1:0];
    end
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
      dbz_q      <= 1'b0;
      cnt_q      <= '0;
      work_hi_q  <= '0;
      work_lo_q  <= '0;
      opnd_q     <= '0;
      is_div_q   <= 1'b0;
      neg_q      <= 1'b0;
      rneg_q     <= 1'b0;
      dbz_pend_q <= 1'b0;
    end else begin
      done_q <= commit;
      if (accept) begin
        is_div_q   <= e_op[1];
        neg_q      <= a_neg ^ b_neg;
        rneg_q     <= a_neg;
        dbz_pend_q <= e_op[1] && (e_b == '0);
        dbz_q      <= 1'b0;
        cnt_q      <= CW'(WIDTH - 1);
        work_hi_q  <= '0;
        work_lo_q  <= e_op[1] ? a_mag : b_mag;
        opnd_q     <= e_op[1] ? b_mag : a_mag;
      end else if (step) begin
        cnt_q     <= cnt_q - CW'(1);
        work_hi_q <= step_hi;
        work_lo_q <= step_lo;
      end else if (commit) begin
        hi_q  <= res_hi;
        lo_q  <= res_lo;
        dbz_q <= dbz_pend_q;
      end
      if (mt_hi) hi_q <= e_a;
      if (mt_lo) lo_q <= e_a;
    end
  end

  assign hi          = hi_q;
  assign lo          = lo_q;
  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  // Covers the issue cycle too, so a dependent decode op cannot slip into execute early.
  assign stall       = d_hilo_use && (busy || (e_start && !e_op[2]));

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: scoreboard of {div_by_zero, hi, lo} popped on done.
// Latency: each op expects exactly 33 busy cycles and a one-cycle done pulse.
// Backpressure: none; stall is checked against d_hilo_use around each op.
module tb_mult_div_unit;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        e_start = 1'b0;
  logic [2:0]  e_op = 3'b000;
  logic [31:0] e_a = '0;
  logic [31:0] e_b = '0;
  logic        d_hilo_use = 1'b0;
  logic [31:0] hi, lo;
  logic        busy, done, div_by_zero, stall;

  int errors = 0;
  int checks = 0;
  logic [64:0] sb_q[$];

  mult_div_unit #(.WIDTH(32)) dut (
    .clock(clock), .reset(reset), .e_start(e_start), .e_op(e_op), .e_a(e_a), .e_b(e_b),
    .d_hilo_use(d_hilo_use), .hi(hi), .lo(lo), .busy(busy), .done(done),
    .div_by_zero(div_by_zero), .stall(stall)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Reference model: {div_by_zero, hi, lo}
  function automatic logic [64:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sp;
    logic [63:0]        up;
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    case (op)
      3'd0: begin
        sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        return {1'b0, sp};
      end
      3'd1: begin
        up = {32'b0, a} * {32'b0, b};
        return {1'b0, up};
      end
      3'd2: begin
        if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b0, 32'd0, 32'h8000_0000};
        return {1'b0, 32'(sa % sb), 32'(sa / sb)};
      end
      default: begin
        if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
        return {1'b0, a % b, a / b};
      end
    endcase
  endfunction

  // Scoreboard consumer: compares committed hi/lo on every done pulse.
  always @(negedge clock) begin
    if (!reset && done) begin
      if (sb_q.size() == 0) begin
        chk("sb_underflow", 64'(done), 64'd0);
      end else begin
        logic [64:0] exp;
        exp = sb_q.pop_front();
        chk("hi", 64'(hi), 64'(exp[63:32]));
        chk("lo", 64'(lo), 64'(exp[31:0]));
        chk("div_by_zero", 64'(div_by_zero), 64'(exp[64]));
      end
    end
  end

  always @(posedge clock) begin
    if (!reset) assert (!(e_start && busy)) else $error("FAIL start_while_busy");
  end

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [64:0] exp, input bit hold_use);
    int n;
    logic [31:0] h0, l0;
    @(negedge clock);
    d_hilo_use = hold_use;
    e_start = 1'b1;
    e_op = op;
    e_a = a;
    e_b = b;
    sb_q.push_back(exp);
    #1;
    chk("stall_issue", 64'(stall), 64'(hold_use));
    h0 = hi;
    l0 = lo;
    @(negedge clock);
    e_start = 1'b0;
    n = 0;
    while (busy && n < 100) begin
      n++;
      if (n == 1) chk("dbz_clear_at_start", 64'(div_by_zero), 64'd0);
      if (hold_use) chk("stall_busy", 64'(stall), 64'd1);
      chk("hilo_hold", {hi, lo}, {h0, l0});
      @(negedge clock);
    end
    chk("busy_cycles", 64'(n), 64'd33);
    chk("done_pulse", 64'(done), 64'd1);
    if (hold_use) chk("stall_release", 64'(stall), 64'd0);
    @(negedge clock);
    chk("done_one_cycle", 64'(done), 64'd0);
    d_hilo_use = 1'b0;
  endtask

  task automatic mt_op(input logic [2:0] op, input logic [31:0] a);
    @(negedge clock);
    d_hilo_use = 1'b1;
    e_start = 1'b1;
    e_op = op;
    e_a = a;
    #1;
    chk("stall_mt", 64'(stall), 64'd0);
    @(negedge clock);
    e_start = 1'b0;
    d_hilo_use = 1'b0;
    chk("busy_mt", 64'(busy), 64'd0);
    chk("done_mt", 64'(done), 64'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] ra, rb;
    logic [2:0]  rop;
    repeat (2) @(negedge clock);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_dbz", 64'(div_by_zero), 64'd0);
    reset = 1'b0;

    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {1'b0, 32'hFFFF_FFFE, 32'h0000_0001}, 1'b0);
    run_op(3'd0, 32'hFFFF_FFFD, 32'd7,         {1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFEB}, 1'b0);
    run_op(3'd2, 32'hFFFF_FFF9, 32'd2,         {1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD}, 1'b0);
    run_op(3'd3, 32'd100,       32'd7,         {1'b0, 32'd2,         32'd14},        1'b0);
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, {1'b0, 32'd0,         32'h8000_0000}, 1'b0);
    run_op(3'd2, 32'hFFFF_FFFB, 32'd0,         {1'b1, 32'hFFFF_FFFB, 32'hFFFF_FFFF}, 1'b0);
    run_op(3'd2, 32'd5,         32'd0,         {1'b1, 32'd5,         32'hFFFF_FFFF}, 1'b0);
    chk("dbz_holds", 64'(div_by_zero), 64'd1);
    mt_op(3'd4, 32'h77);
    chk("mthi_val", 64'(hi), 64'h77);
    chk("dbz_after_mthi", 64'(div_by_zero), 64'd1);
    run_op(3'd1, 32'd2, 32'd3, {1'b0, 32'd0, 32'd6}, 1'b0);

    for (int i = 0; i < 8; i++) begin
      rop = 3'($urandom_range(0, 3));
      ra = $urandom;
      rb = (i == 3) ? 32'd0 : ((i % 2 == 0) ? $urandom : 32'($urandom_range(1, 1000)));
      if (i == 5) ra = 32'h8000_0000;
      run_op(rop, ra, rb, model(rop, ra, rb), 1'b0);
    end

    // Held HI/LO consumer in decode across a whole signed multiply.
    run_op(3'd0, 32'h1234_5678, 32'hFFFF_FFFE, model(3'd0, 32'h1234_5678, 32'hFFFF_FFFE), 1'b1);

    // Reset in the middle of CALC aborts the op without committing.
    @(negedge clock);
    e_start = 1'b1;
    e_op = 3'd1;
    e_a = 32'hDEAD_BEEF;
    e_b = 32'h1234_5678;
    @(negedge clock);
    e_start = 1'b0;
    repeat (10) @(negedge clock);
    chk("busy_before_reset", 64'(busy), 64'd1);
    #2 reset = 1'b1;
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_hi", 64'(hi), 64'd0);
    chk("arst_lo", 64'(lo), 64'd0);
    chk("arst_done", 64'(done), 64'd0);
    @(negedge clock);
    reset = 1'b0;
    repeat (40) @(negedge clock);
    chk("no_commit_after_abort", {hi, lo}, 64'd0);

    mt_op(3'd4, 32'h1234);
    chk("mthi_hi", 64'(hi), 64'h1234);
    chk("mthi_lo", 64'(lo), 64'd0);
    mt_op(3'd5, 32'hABCD);
    chk("mtlo_lo", 64'(lo), 64'hABCD);
    chk("mtlo_hi", 64'(hi), 64'h1234);
    mt_op(3'd6, 32'hFFFF_FFFF);
    chk("noop_hilo", {hi, lo}, {32'h1234, 32'hABCD});

    chk("sb_leftover", 64'(sb_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
